sht40_measure_sequencer: RTL and testbench
==========================================

// Module: sht40_measure_sequencer
// PURPOSE
//  Upstream controller for i2c_master. Runs one SHT40 high-precision measurement per start pulse.
//  Sequence: write cmd MEAS_CMD, wait conversion, read 6 bytes (T_msb, T_lsb, T_crc, H_msb, H_lsb, H_crc).
//  Checks CRC-8 per word, drives CRC_Error back into the master, presents raw temp/humidity words with a valid strobe.
// PARAMETERS
//  SENSOR_ADDR  7'h44      7-bit I2C address driven on Peripheral_Address
//  MEAS_CMD     8'hFD      measurement command byte
//  MEAS_CYCLES  200000     clk cycles waited between cmd completion and read (10 ms @ 20 MHz)
//  NUM_BYTES    6          bytes per read; SHT_Reads driven as NUM_BYTES-1
// PORTS
//  clk                      in   1   system clock
//  rst                      in   1   asynchronous active-high reset
//  start                    in   1   1-cycle pulse: begin measurement; ignored unless busy=0
//  busy                     out  1   high from accepted start until data_valid/crc_fail pulse
//  temp_raw                 out  16  {T_msb,T_lsb} of last good read
//  hum_raw                  out  16  {H_msb,H_lsb} of last good read
//  data_valid               out  1   1-cycle pulse: temp_raw/hum_raw updated
//  crc_fail                 out  1   1-cycle pulse: read discarded on CRC mismatch
//  Processor_Ready          out  1   request to i2c_master (level, held until master leaves state 3'b000)
//  Peripheral_Address       out  7   constant SENSOR_ADDR
//  Command_Data_Frames      out  8   MEAS_CMD
//  r_or_w                   out  1   0 = write transaction, 1 = read transaction
//  i2c_writes               out  1   number of data frames after address; 1 in CMD, 0 in READ
//  SHT_Reads                out  4   NUM_BYTES-1
//  CRC_Error                out  1   held high 1 cycle on mismatch; master aborts to stop
//  Frames_Read              in   1   master consumed command frame
//  Data_Received            in   8   last byte from master
//  Output_Received_Counter  in   4   master byte count; any change = new byte in Data_Received
//  Master_State_Out         in   3   master state; 3'b000 = idle/awaiting Processor_Ready
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except Peripheral_Address=SENSOR_ADDR, Command_Data_Frames=MEAS_CMD,
//    SHT_Reads=NUM_BYTES-1; temp_raw=hum_raw=0; counters and byte buffer 0. Reset mid-transaction aborts immediately.
//  FSM:
//    IDLE      : start & ~busy -> CMD_REQ; busy<=1.
//    CMD_REQ   : r_or_w=0, i2c_writes=1, Processor_Ready=1; when Master_State_Out!=0 -> CMD_WAIT, Ready<=0.
//    CMD_WAIT  : Frames_Read seen (latched) AND Master_State_Out==0 -> MEAS_WAIT, wait_cnt<=0.
//    MEAS_WAIT : wait_cnt++ ; at wait_cnt==MEAS_CYCLES-1 -> RD_REQ (exactly MEAS_CYCLES cycles).
//    RD_REQ    : r_or_w=1, i2c_writes=0, Processor_Ready=1; Master_State_Out!=0 -> COLLECT, Ready<=0, idx<=0.
//    COLLECT   : cnt_q<=Output_Received_Counter each cycle; (Output_Received_Counter!=cnt_q) -> buf[idx]<=Data_Received, idx++.
//                If CRC check fails on idx 2 or 5 -> CRC_Error=1 one cycle, crc_fail pulse, -> ABORT.
//                idx reaches NUM_BYTES -> DONE.
//    ABORT     : wait Master_State_Out==0 -> IDLE, busy<=0.
//    DONE      : temp_raw/hum_raw load, data_valid pulse, busy<=0 -> IDLE (1 cycle).
//  CRC-8: poly 0x31, init 0xFF, no reflection, no final XOR, over the 2 data bytes; compare to 3rd byte.
//    Computed combinationally at byte arrival (bitwise loop over 8 bits).
//  Counter wrap 15->0 counts as a change. Byte arrival while not in COLLECT is ignored.
//  start while busy ignored; start same cycle as DONE ignored (busy still high).
//  data_valid and crc_fail never high together; outputs hold last good values after crc_fail.
// CONFIGURATION
//  SHT40_CRC_CHECK_EN defined: CRC check as above.
//  Not defined: no CRC logic; CRC_Error tied 0, crc_fail tied 0; all 6 bytes accepted, CRC bytes discarded.
// TESTING
//  1. start with master model, bytes BE EF 92 66 66 93 -> data_valid, temp_raw=16'hBEEF, hum_raw=16'h6666.
//  2. same but 3rd byte 0x93 -> CRC_Error 1 cycle after 3rd byte, crc_fail pulse, no data_valid, outputs unchanged.
//  3. MEAS_CYCLES=16: Processor_Ready for read rises exactly 16 cycles after CMD_WAIT exit.
//  4. start pulses during busy -> ignored; exactly one command and one read issued.
//  5. assert rst in COLLECT after 3 bytes -> all outputs at reset values next cycle; new start runs cleanly.
//  6. SHT40_CRC_CHECK_EN undefined, bad CRC bytes -> data_valid still pulses, CRC_Error stays 0.

Source files
------------

// File: rtl/sht40_measure_sequencer.sv
// sht40_measure_sequencer: drives i2c_master through one SHT40 measurement per start pulse.
// Define SHT40_CRC_CHECK_EN to enable CRC-8 checking of the temperature and humidity words.
module sht40_measure_sequencer #(
    parameter logic [6:0]  SENSOR_ADDR = 7'h44,
    parameter logic [7:0]  MEAS_CMD    = 8'hFD,
    parameter int unsigned MEAS_CYCLES = 200000,
    parameter int unsigned NUM_BYTES   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic [15:0] temp_raw,
    output logic [15:0] hum_raw,
    output logic        data_valid,
    output logic        crc_fail,
    output logic        Processor_Ready,
    output logic [6:0]  Peripheral_Address,
    output logic [7:0]  Command_Data_Frames,
    output logic        r_or_w,
    output logic        i2c_writes,
    output logic [3:0]  SHT_Reads,
    output logic        CRC_Error,
    input  logic        Frames_Read,
    input  logic [7:0]  Data_Received,
    input  logic [3:0]  Output_Received_Counter,
    input  logic [2:0]  Master_State_Out
);

    localparam int WW = (MEAS_CYCLES > 1) ? $clog2(MEAS_CYCLES) : 1;
    localparam int IW = $clog2(NUM_BYTES + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEAS_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_BYTES - 1);
    localparam logic [IW-1:0] T_CRC_IDX = IW'(2);
    localparam logic [IW-1:0] H_CRC_IDX = IW'(5);

    typedef enum logic [2:0] {
        IDLE, CMD_REQ, CMD_WAIT, MEAS_WAIT,
        RD_REQ, COLLECT, ABORT, DONE
    } state_t;

    state_t        state;
    logic          frames_seen;
    logic [WW-1:0] wait_cnt;
    logic [IW-1:0] idx;
    logic [3:0]    cnt_q;
    logic [31:0]   data_q;

    logic byte_in;
    logic crc_byte;
    logic last_byte;

    assign Peripheral_Address  = SENSOR_ADDR;
    assign Command_Data_Frames = MEAS_CMD;
    assign SHT_Reads           = 4'(NUM_BYTES - 1);

    // Any counter movement, including the 15->0 wrap, marks a fresh byte.
    assign byte_in   = (Output_Received_Counter != cnt_q);
    assign crc_byte  = (idx == T_CRC_IDX) || (idx == H_CRC_IDX);
    assign last_byte = (idx == LAST_IDX);

`ifdef SHT40_CRC_CHECK_EN
    function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] c;
        c = 8'hFF ^ a;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        c = c ^ b;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        return c;
    endfunction

    logic crc_bad;
    // The two data bytes of the current word sit in the low half of data_q.
    assign crc_bad = (crc8(data_q[15:8], data_q[7:0]) != Data_Received);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            temp_raw        <= 16'h0;
            hum_raw         <= 16'h0;
            data_valid      <= 1'b0;
            crc_fail        <= 1'b0;
            Processor_Ready <= 1'b0;
            r_or_w          <= 1'b0;
            i2c_writes      <= 1'b0;
            CRC_Error       <= 1'b0;
            frames_seen     <= 1'b0;
            wait_cnt        <= '0;
            idx             <= '0;
            cnt_q           <= 4'h0;
            data_q          <= 32'h0;
        end else begin
            data_valid <= 1'b0;
            crc_fail   <= 1'b0;
            CRC_Error  <= 1'b0;
            cnt_q      <= Output_Received_Counter;
            unique case (state)
                IDLE: begin
                    if (start && !busy) begin
                        state           <= CMD_REQ;
                        busy            <= 1'b1;
                        r_or_w          <= 1'b0;
                        i2c_writes      <= 1'b1;
                        Processor_Ready <= 1'b1;
                        frames_seen     <= 1'b0;
                    end
                end
                CMD_REQ: begin
                    if (Frames_Read)
                        frames_seen <= 1'b1;
                    if (Master_State_Out != 3'b000) begin
                        state           <= CMD_WAIT;
                        Processor_Ready <= 1'b0;
                    end
                end
                CMD_WAIT: begin
                    if ((frames_seen || Frames_Read) && Master_State_Out == 3'b000) begin
                        state    <= MEAS_WAIT;
                        wait_cnt <= '0;
                    end else if (Frames_Read) begin
                        frames_seen <= 1'b1;
                    end
                end
                MEAS_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state           <= RD_REQ;
                        r_or_w          <= 1'b1;
                        i2c_writes      <= 1'b0;
                        Processor_Ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RD_REQ: begin
                    if (Master_State_Out != 3'b000) begin
                        state           <= COLLECT;
                        Processor_Ready <= 1'b0;
                        idx             <= '0;
                    end
                end
                COLLECT: begin
                    if (byte_in) begin
                        idx <= idx + 1'b1;
                        if (!crc_byte)
                            data_q <= {data_q[23:0], Data_Received};
`ifdef SHT40_CRC_CHECK_EN
                        if (crc_byte && crc_bad) begin
                            CRC_Error <= 1'b1;
                            crc_fail  <= 1'b1;
                            state     <= ABORT;
                        end else if (last_byte) begin
                            state <= DONE;
                        end
`else
                        if (last_byte)
                            state <= DONE;
`endif
                    end
                end
                ABORT: begin
                    if (Master_State_Out == 3'b000) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    temp_raw   <= data_q[31:16];
                    hum_raw    <= data_q[15:0];
                    data_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sht40_measure_sequencer.sv
// Bench for sht40_measure_sequencer: table vectors plus random reads against an i2c_master model.
// Expectations follow SHT40_CRC_CHECK_EN when it is defined for the whole compile.
module tb_sht40_measure_sequencer;

    localparam int MC = 16;
`ifdef SHT40_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic [15:0] temp_raw;
    logic [15:0] hum_raw;
    logic        data_valid;
    logic        crc_fail;
    logic        Processor_Ready;
    logic [6:0]  Peripheral_Address;
    logic [7:0]  Command_Data_Frames;
    logic        r_or_w;
    logic        i2c_writes;
    logic [3:0]  SHT_Reads;
    logic        CRC_Error;
    logic        Frames_Read;
    logic [7:0]  Data_Received;
    logic [3:0]  Output_Received_Counter;
    logic [2:0]  Master_State_Out;

    sht40_measure_sequencer #(
        .SENSOR_ADDR(7'h44),
        .MEAS_CMD(8'hFD),
        .MEAS_CYCLES(MC),
        .NUM_BYTES(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .temp_raw(temp_raw),
        .hum_raw(hum_raw),
        .data_valid(data_valid),
        .crc_fail(crc_fail),
        .Processor_Ready(Processor_Ready),
        .Peripheral_Address(Peripheral_Address),
        .Command_Data_Frames(Command_Data_Frames),
        .r_or_w(r_or_w),
        .i2c_writes(i2c_writes),
        .SHT_Reads(SHT_Reads),
        .CRC_Error(CRC_Error),
        .Frames_Read(Frames_Read),
        .Data_Received(Data_Received),
        .Output_Received_Counter(Output_Received_Counter),
        .Master_State_Out(Master_State_Out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int   n_dv = 0, n_cf = 0, n_ce = 0, n_both = 0, n_rdy = 0;
    logic rdy_d = 1'b0;

    always @(negedge clk) begin
        if (data_valid) n_dv <= n_dv + 1;
        if (crc_fail) n_cf <= n_cf + 1;
        if (CRC_Error) n_ce <= n_ce + 1;
        if (data_valid && crc_fail) n_both <= n_both + 1;
        if (Processor_Ready && !rdy_d) n_rdy <= n_rdy + 1;
        rdy_d <= Processor_Ready;
    end

    logic [3:0]  ocnt = 4'd13;
    logic [15:0] exp_t = 16'h0;
    logic [15:0] exp_h = 16'h0;

    typedef struct {
        logic [47:0] bytes;
        int          fail_at;
        logic [15:0] t;
        logic [15:0] h;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC as the remainder of the init-adjusted message times x^8 modulo x^8+x^5+x^4+1.
    function automatic logic [7:0] model_crc(input logic [7:0] a, input logic [7:0] b);
        logic [23:0] v;
        v = {a ^ 8'hFF, b, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (v[i]) v = v ^ (24'h131 << (i - 8));
        return v[7:0];
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_temp"}, temp_raw, 0);
        check({tag, "_hum"}, hum_raw, 0);
        check({tag, "_dv"}, data_valid, 0);
        check({tag, "_cf"}, crc_fail, 0);
        check({tag, "_ready"}, Processor_Ready, 0);
        check({tag, "_rw"}, r_or_w, 0);
        check({tag, "_writes"}, i2c_writes, 0);
        check({tag, "_crcerr"}, CRC_Error, 0);
        check({tag, "_addr"}, Peripheral_Address, 7'h44);
        check({tag, "_cmd"}, Command_Data_Frames, 8'hFD);
        check({tag, "_reads"}, SHT_Reads, 4'd5);
    endtask

    task automatic run_txn(input logic [47:0] v, input int fail_at, input int rst_after, input bit spam);
        int n;
        bit got;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_on_start", busy, 1);
        check("cmd_ready", Processor_Ready, 1);
        check("cmd_rw", r_or_w, 0);
        check("cmd_writes", i2c_writes, 1);
        Master_State_Out = 3'b010;
        tick();
        tick();
        check("cmd_ready_drop", Processor_Ready, 0);
        Frames_Read = 1'b1;
        tick();
        Frames_Read = 1'b0;
        tick();
        // The exit edge follows this negedge; ready is visible MC edges later, i.e. at tick MC+1.
        Master_State_Out = 3'b000;
        n = 0;
        got = 1'b0;
        while (!got && n < MC + 40) begin
            start = spam;
            tick();
            n++;
            got = Processor_Ready;
        end
        start = 1'b0;
        check("meas_wait_len", n, MC + 1);
        check("rd_rw", r_or_w, 1);
        check("rd_writes", i2c_writes, 0);
        check("rd_count", SHT_Reads, 4'd5);
        Master_State_Out = 3'b100;
        tick();
        tick();
        check("rd_ready_drop", Processor_Ready, 0);
        for (int k = 0; k < 6; k++) begin
            if (k == rst_after) begin
                rst = 1'b1;
                Master_State_Out = 3'b000;
                tick();
                check_reset_vals("mid_rst");
                rst = 1'b0;
                tick();
                return;
            end
            Data_Received = v[47-8*k -: 8];
            ocnt = ocnt + 4'd1;
            Output_Received_Counter = ocnt;
            start = spam;
            tick();
            start = 1'b0;
            if (k == fail_at) begin
                check("crc_err_hi", CRC_Error, 1);
                check("crc_fail_hi", crc_fail, 1);
                tick();
                check("crc_err_lo", CRC_Error, 0);
                check("dv_lo_on_fail", data_valid, 0);
                Master_State_Out = 3'b000;
                tick();
                tick();
                check("busy_after_abort", busy, 0);
                return;
            end
            if (k == 5) begin
                Master_State_Out = 3'b000;
                start = spam;
            end
            tick();
            start = 1'b0;
        end
        check("dv_pulse", data_valid, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic do_txn(input logic [47:0] v, input int fail_raw,
                          input logic [15:0] t, input logic [15:0] h, input bit spam);
        int s_dv, s_cf, s_ce, s_both, s_rdy, fa;
        fa = CRC_ON ? fail_raw : -1;
        s_dv = n_dv; s_cf = n_cf; s_ce = n_ce; s_both = n_both; s_rdy = n_rdy;
        run_txn(v, fa, -1, spam);
        repeat (3) tick();
        check("ready_idle", Processor_Ready, 0);
        check("busy_idle", busy, 0);
        check("n_dv", n_dv - s_dv, (fa < 0) ? 1 : 0);
        check("n_cf", n_cf - s_cf, (fa < 0) ? 0 : 1);
        check("n_crcerr", n_ce - s_ce, (fa < 0) ? 0 : 1);
        check("n_both", n_both - s_both, 0);
        check("n_requests", n_rdy - s_rdy, 2);
        if (fa < 0) begin
            exp_t = t;
            exp_h = h;
        end
        check("temp_raw", temp_raw, exp_t);
        check("hum_raw", hum_raw, exp_h);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{48'hBEEF92_666693, -1, 16'hBEEF, 16'h6666};
        tbl[1] = '{48'hBEEF93_666693,  2, 16'hBEEF, 16'h6666};
        tbl[2] = '{48'h666693_BEEF93,  5, 16'h6666, 16'hBEEF};
        tbl[3] = '{48'h666693_BEEF92, -1, 16'h6666, 16'hBEEF};
        tbl[4] = '{48'hBEEF92_BEEF92, -1, 16'hBEEF, 16'hBEEF};

        rst = 1'b1;
        start = 1'b0;
        Frames_Read = 1'b0;
        Data_Received = 8'h00;
        Output_Received_Counter = ocnt;
        Master_State_Out = 3'b000;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            do_txn(tbl[i].bytes, tbl[i].fail_at, tbl[i].t, tbl[i].h, i == 3);

        run_txn(tbl[0].bytes, -1, 3, 1'b0);
        exp_t = 16'h0;
        exp_h = 16'h0;
        do_txn(tbl[0].bytes, tbl[0].fail_at, tbl[0].t, tbl[0].h, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic [47:0] v;
            int fa;
            v = {$urandom, 16'($urandom)};
            if ($urandom_range(0, 1) == 1) v[31:24] = model_crc(v[47:40], v[39:32]);
            if ($urandom_range(0, 1) == 1) v[7:0] = model_crc(v[23:16], v[15:8]);
            if (v[31:24] != model_crc(v[47:40], v[39:32])) fa = 2;
            else if (v[7:0] != model_crc(v[23:16], v[15:8])) fa = 5;
            else fa = -1;
            do_txn(v, fa, v[47:32], v[23:8], r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
